// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM state encoding,
// register byte offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } uart_tx_state_t;

  localparam logic [3:0] UART_REG_TXDATA = 4'h0;
  localparam logic [3:0] UART_REG_STATUS = 4'h4;
  localparam logic [3:0] UART_REG_BAUD   = 4'h8;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_PARITY    = 4;
  localparam int unsigned STAT_COUNT_LSB = 8;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is visible on rdata
// without a pop. A push into a full FIFO is accepted if a pop happens that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     accept,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign count  = wr_ptr - rd_ptr;
  assign rdata  = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/device_uart_tx_fifo.sv
// Memory-mapped buffered UART transmitter: register decode, baud counter, FSM
// and shifter. Define UART_TX_PARITY_EN to add an even-parity bit (8-E-1).
module device_uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 867
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wen,
  input  logic        bus_ren,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        TxD
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic [3:0]     reg_off;
  logic           wr_txdata, wr_baud, rd_status;
  logic           fifo_pop, fifo_accept, fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [CW-1:0]  fifo_count;
  logic           ovf;
  logic [15:0]    div_reg;
  logic [15:0]    count_ext;
  logic [7:0]     count_sat;
  logic [31:0]    status_word, rdata_n;

  uart_tx_state_t state, state_n;
  logic [15:0]    cnt, cnt_n, div_act, div_act_n;
  logic [7:0]     shift, shift_n;
  logic [2:0]     bit_idx, bit_n;
  logic           par, par_n, txd_n, load, boundary;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

  assign reg_off   = {bus_addr[3:2], 2'b00};
  assign wr_txdata = bus_wen && (reg_off == UART_REG_TXDATA);
  assign wr_baud   = bus_wen && (reg_off == UART_REG_BAUD);
  assign rd_status = bus_ren && !bus_wen && (reg_off == UART_REG_STATUS);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (wr_txdata),
    .wdata  (bus_wdata[7:0]),
    .accept (fifo_accept),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Count field is 8 bits; a full 256-deep FIFO saturates rather than wrapping to 0.
  assign count_ext = 16'(fifo_count);
  assign count_sat = (count_ext > 16'd255) ? 8'hFF : count_ext[7:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    status_word                 = '0;
    status_word[STAT_EMPTY]     = fifo_empty;
    status_word[STAT_FULL]      = fifo_full;
    status_word[STAT_BUSY]      = (state != TX_IDLE);
    status_word[STAT_OVF]       = ovf;
    status_word[STAT_PARITY]    = PARITY_EN;
    status_word[STAT_COUNT_LSB +: 8] = count_sat;

    rdata_n = '0;
    if (!bus_wen) begin
      case (reg_off)
        UART_REG_STATUS: rdata_n = status_word;
        UART_REG_BAUD:   rdata_n = {16'h0000, div_reg};
        default:         rdata_n = '0;
      endcase
    end
  end

  // A STATUS read clears ovf, but an overflow in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg   <= 16'(DIV_RESET);
      ovf       <= 1'b0;
      bus_rdata <= '0;
    end else begin
      if (wr_baud) div_reg <= bus_wdata[15:0];
      ovf <= (wr_txdata && !fifo_accept) || (ovf && !rd_status);
      if (bus_ren) bus_rdata <= rdata_n;
    end
  end

  assign boundary = (cnt == 16'd0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_act_n = div_act;
    shift_n   = shift;
    bit_n     = bit_idx;
    par_n     = par;
    load      = 1'b0;
    fifo_pop  = 1'b0;

    if (state != TX_IDLE) cnt_n = boundary ? div_act : cnt - 16'd1;

    case (state)
      TX_IDLE:  if (!fifo_empty) load = 1'b1;
      TX_START: if (boundary) begin
        state_n = TX_DATA;
        bit_n   = 3'd0;
      end
      TX_DATA: if (boundary) begin
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = TX_PARITY;
`else
          state_n = TX_STOP;
`endif
        end else begin
          bit_n   = bit_idx + 3'd1;
          shift_n = shift >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: if (boundary) state_n = TX_STOP;
`endif
      TX_STOP: if (boundary) begin
        if (!fifo_empty) load = 1'b1;
        else             state_n = TX_IDLE;
      end
      default: state_n = TX_IDLE;
    endcase

    // Frame start: pop, load shifter and latch the divisor for the whole frame.
    if (load) begin
      fifo_pop  = 1'b1;
      state_n   = TX_START;
      shift_n   = fifo_rdata;
      par_n     = even_parity(fifo_rdata);
      div_act_n = div_reg;
      cnt_n     = div_reg;
      bit_n     = 3'd0;
    end

    case (state_n)
      TX_START:  txd_n = 1'b0;
      TX_DATA:   txd_n = shift_n[0];
      TX_PARITY: txd_n = par_n;
      default:   txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      div_act <= 16'(DIV_RESET);
      shift   <= '0;
      bit_idx <= '0;
      par     <= 1'b0;
      TxD     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_act <= div_act_n;
      shift   <= shift_n;
      bit_idx <= bit_n;
      par     <= par_n;
      TxD     <= txd_n;
    end
  end

endmodule

// File: tb/tb_device_uart_tx_fifo.sv
// Self-checking bench: a line monitor decodes TxD frames against a queue of
// expected bytes/bit periods; scenario tasks check registers and timing.
module tb_device_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int          NB   = PAR ? 11 : 10;
  localparam logic [31:0] PBIT = PAR ? 32'h10 : 32'h0;

  typedef struct {
    logic [7:0] data;
    int         period;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  bus_addr;
  logic        bus_wen, bus_ren;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        TxD;

  exp_t exp_q[$];
  int   start_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   mon_active = 1'b0;

  device_uart_tx_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wen   (bus_wen),
    .bus_ren   (bus_ren),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .TxD       (TxD)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (PAR && i == 9) return ^d;
    return 1'b1;
  endfunction

  // Line monitor: every cycle of every bit must carry the expected level.
  initial begin
    exp_t cur;
    int   bit_i, k;
    bit   bad, bogus;
    logic seen, eb;
    cur = '{8'h00, 1};
    bit_i = 0; k = 0; bad = 1'b0; bogus = 1'b0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && TxD === 1'b0) begin
          mon_active = 1'b1; bit_i = 0; k = 0; bad = 1'b0;
          start_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            bogus = 1'b1; cur = '{8'h00, 1};
            tests++; fails++;
            $display("FAIL unexpected_frame: start at cycle %0d, required no frame", cyc);
          end else begin
            bogus = 1'b0; cur = exp_q.pop_front();
          end
        end
        if (mon_active) begin
          eb = exp_bit(cur.data, bit_i);
          if (TxD !== eb && !bad) begin bad = 1'b1; seen = TxD; end
          k++;
          if (k == cur.period) begin
            if (!bogus) begin
              tests++;
              if (bad) begin
                fails++;
                $display("FAIL frame_bit: byte=%02h bit=%0d TxD=%b required %b", cur.data, bit_i, seen, eb);
              end
            end
            k = 0; bad = 1'b0; bit_i++;
            if (bit_i == NB) mon_active = 1'b0;
          end
        end
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a; bus_ren = 1'b1;
    @(negedge clk);
    bus_ren = 1'b0;
    d = bus_rdata;
  endtask

  task automatic send(input logic [7:0] b, input int period);
    exp_q.push_back('{b, period});
    bus_write(4'h0, {24'h0, b});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || mon_active) begin
      fails++;
      $display("FAIL %s_timeout: pending=%0d active=%0b, required 0 pending and idle", name, exp_q.size(), mon_active);
      exp_q.delete();
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %08h, required %08h", name, got, want);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0; bus_addr = '0; bus_wen = 1'b0; bus_ren = 1'b0; bus_wdata = '0;
    repeat (3) @(negedge clk);
    tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b, required 1", TxD); end
    tests++; if (bus_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %08h, required 0", bus_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(4'h4, d); expect_word("reset_status", d, 32'h1 | PBIT);
    bus_read(4'h8, d); expect_word("reset_baud", d, 32'd867);
    bus_read(4'h0, d); expect_word("txdata_read", d, 32'h0);
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read(4'h8, d); expect_word("baud_after_c_write", d, 32'd867);
    repeat (3) @(negedge clk);
    tests++; if (bus_rdata !== 32'd867) begin fails++; $display("FAIL rdata_hold: got %08h, required %08h", bus_rdata, 32'd867); end
    bus_read(4'hC, d); expect_word("reg_c_read", d, 32'h0);
    bus_read(4'h8, d);
    // Colliding strobes: the write lands and the read returns 0.
    bus_addr = 4'h8; bus_wdata = 32'd5; bus_wen = 1'b1; bus_ren = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0; bus_ren = 1'b0;
    expect_word("collision_rdata", bus_rdata, 32'h0);
    bus_read(4'h8, d); expect_word("collision_baud", d, 32'd5);
  endtask

  task automatic test_single_frame;
    logic [31:0] d;
    int c;
    bus_write(4'h8, 32'd3);
    start_q.delete();
    c = cyc;
    send(8'h55, 4);
    wait_done("single", 200);
    tests++;
    if (start_q.size() != 1 || start_q[0] != c + 2) begin
      fails++;
      $display("FAIL single_latency: frames=%0d start=%0d, required 1 frame at %0d",
               start_q.size(), (start_q.size() > 0) ? start_q[0] : -1, c + 2);
    end
    repeat (4) @(negedge clk);
    tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL single_idle_txd: got %b, required 1", TxD); end
    bus_read(4'h4, d); expect_word("single_status", d, 32'h1 | PBIT);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    int c, s;
    bus_write(4'h8, 32'd0);
    start_q.delete();
    c = cyc;
    send(8'h41, 1); send(8'h42, 1); send(8'h43, 1);
    s = c + 2;
    while (cyc < s + 3*NB - 1) @(negedge clk);
    bus_read(4'h4, d); expect_word("b2b_busy_last", d, 32'h5 | PBIT);
    bus_read(4'h4, d); expect_word("b2b_busy_fall", d, 32'h1 | PBIT);
    wait_done("b2b", 100);
    tests++;
    if (start_q.size() != 3 || start_q[0] != s || start_q[1] != s + NB || start_q[2] != s + 2*NB) begin
      fails++;
      $display("FAIL b2b_starts: frames=%0d, required starts %0d,%0d,%0d", start_q.size(), s, s + NB, s + 2*NB);
    end
  endtask

  task automatic test_baud_change;
    logic [31:0] d;
    bus_write(4'h8, 32'd3);
    start_q.delete();
    send(8'hA5, 4);
    send(8'h3C, 8);
    repeat (6) @(negedge clk);
    bus_write(4'h8, 32'd7);
    bus_read(4'h8, d); expect_word("baud_readback", d, 32'd7);
    wait_done("baud_change", 400);
    tests++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != NB*4) begin
      fails++;
      $display("FAIL baud_change_gap: frames=%0d, required 2 frames %0d cycles apart", start_q.size(), NB*4);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    bus_write(4'h8, 32'd100);
    start_q.delete();
    for (int i = 0; i < 18; i++) begin
      if (i < 17) send(8'(i + 8'h10), 101);
      else        bus_write(4'h0, 32'(i + 8'h10));
    end
    bus_read(4'h4, d); expect_word("ovf_status_1", d, 32'h100E | PBIT);
    bus_read(4'h4, d); expect_word("ovf_status_2", d, 32'h1006 | PBIT);
    wait_done("overflow", 17*NB*101 + 200);
    repeat (20) @(negedge clk);
    tests++;
    if (start_q.size() != 17) begin
      fails++;
      $display("FAIL ovf_frames: got %0d frames, required 17", start_q.size());
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    bus_write(4'h8, 32'd3);
    start_q.delete();
    send(8'h07, 4);
    send(8'h03, 4);
    wait_done("parity", 300);
    tests++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] != 44) begin
      fails++;
      $display("FAIL parity_frame_len: frames=%0d, required 2 frames 44 cycles apart", start_q.size());
    end
  endtask
`endif

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int c, s;
    bus_write(4'h8, 32'd3);
    start_q.delete();
    c = cyc;
    send(8'h00, 4);
    bus_write(4'h0, 32'h12);
    s = c + 2;
    while (cyc < s + 14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if (TxD !== 1'b1) begin fails++; $display("FAIL abort_txd: got %b, required 1", TxD); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(4'h4, d); expect_word("abort_status", d, 32'h1 | PBIT);
    bus_read(4'h8, d); expect_word("abort_baud", d, 32'd867);
    repeat (300) @(negedge clk);
    tests++;
    if (start_q.size() != 1 || exp_q.size() != 0 || TxD !== 1'b1) begin
      fails++;
      $display("FAIL abort_no_frames: frames=%0d pending=%0d TxD=%b, required 1 frame 0 pending TxD=1",
               start_q.size(), exp_q.size(), TxD);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_baud_change();
    test_overflow();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
